// File: rtl/utils_pkg.sv
// Shared CRC32 helpers and constants for the FCS stream arbiter.
// The CRC register is kept in MSB-first (non-reflected) form; byte/result reversal yields Ethernet FCS.
package utils_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    typedef enum logic {
        IDLE,
        PASS
    } fcs_arb_state_t;

    function automatic logic [7:0] bit_reverse8(input logic [7:0] d);
        logic [7:0] r;
        r = '0;
        for (int unsigned i = 0; i < 8; i++) r[i] = d[7-i];
        return r;
    endfunction

    function automatic logic [31:0] bit_reverse32(input logic [31:0] d);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) r[i] = d[31-i];
        return r;
    endfunction

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {bit_reverse8(d), 24'h000000};
        for (int unsigned k = 0; k < 8; k++)
            c = c[31] ? ((c << 1) ^ CRC32_POLY) : (c << 1);
        return c;
    endfunction

endpackage

// File: rtl/crc32_d64.sv
// Combinational CRC32 update over one 64-bit beat; only bytes with keep set are folded in, lowest byte first.
module crc32_d64
    import utils_pkg::*;
(
    input  logic [63:0] data,
    input  logic [7:0]  keep,
    input  logic [31:0] crc_in,
    output logic [31:0] crc_out
);

    always_comb begin
        crc_out = crc_in;
        for (int unsigned i = 0; i < 8; i++)
            if (keep[i]) crc_out = crc32_byte(crc_out, data[8*i +: 8]);
    end

endmodule

// File: rtl/fcs_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing one CRC32 engine; emits FCS + source ID after each packet.
// Optional FCS_CHECK_EN adds fcs_ok, flagging packets that already end in a valid FCS.
module fcs_stream_arbiter
    import utils_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ*64-1:0] s_tdata,
    input  logic [NREQ*8-1:0]  s_tkeep,
    input  logic [NREQ-1:0]    s_tvalid,
    input  logic [NREQ-1:0]    s_tlast,
    output logic [NREQ-1:0]    s_tready,
    output logic [63:0]        m_tdata,
    output logic [7:0]         m_tkeep,
    output logic               m_tvalid,
    output logic               m_tlast,
    output logic [IDW-1:0]     m_tid,
    input  logic               m_tready,
    output logic [31:0]        fcs_data,
    output logic [IDW-1:0]     fcs_id,
    output logic               fcs_valid
`ifdef FCS_CHECK_EN
    ,
    output logic               fcs_ok
`endif
);

    localparam int unsigned NREQ_U = NREQ;

    fcs_arb_state_t state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] last_grant_q;
    logic [31:0]    crc_q, crc_next;
    logic           hs;
    logic           arb_found;
    int unsigned    arb_idx;

    crc32_d64 u_crc (
        .data    (m_tdata),
        .keep    (m_tkeep),
        .crc_in  (crc_q),
        .crc_out (crc_next)
    );

    assign hs    = m_tvalid && m_tready;
    assign m_tid = grant_q;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        s_tready  = '0;
        m_tdata   = '0;
        m_tkeep   = '0;
        m_tvalid  = 1'b0;
        m_tlast   = 1'b0;
        arb_found = 1'b0;
        arb_idx   = 0;
        case (state_q)
            IDLE: begin
                // Scan candidates in priority order starting just after the last winner.
                for (int unsigned k = 0; k < NREQ_U; k++) begin
                    arb_idx = (32'(last_grant_q) + 1 + k) % NREQ_U;
                    for (int unsigned j = 0; j < NREQ_U; j++) begin
                        if (!arb_found && j == arb_idx && s_tvalid[j]) begin
                            arb_found = 1'b1;
                            grant_d   = IDW'(j);
                        end
                    end
                end
                if (arb_found) state_d = PASS;
            end
            PASS: begin
                for (int unsigned i = 0; i < NREQ_U; i++) begin
                    if (grant_q == IDW'(i)) begin
                        m_tdata     = s_tdata[64*i +: 64];
                        m_tkeep     = s_tkeep[8*i +: 8];
                        m_tvalid    = s_tvalid[i];
                        m_tlast     = s_tlast[i];
                        s_tready[i] = m_tready;
                    end
                end
                if (hs && m_tlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IDW'(NREQ - 1);
            crc_q        <= CRC32_INIT;
            fcs_valid    <= 1'b0;
            fcs_data     <= '0;
            fcs_id       <= '0;
`ifdef FCS_CHECK_EN
            fcs_ok       <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            fcs_valid <= 1'b0;
            if (state_q == IDLE) begin
                crc_q <= CRC32_INIT;
            end else if (hs) begin
                crc_q <= crc_next;
                if (m_tlast) begin
                    fcs_valid    <= 1'b1;
                    fcs_data     <= ~bit_reverse32(crc_next);
                    fcs_id       <= grant_q;
                    last_grant_q <= grant_q;
`ifdef FCS_CHECK_EN
                    fcs_ok       <= (bit_reverse32(crc_next) == CRC32_RESIDUE);
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_fcs_stream_arbiter.sv
// Self-checking bench for fcs_stream_arbiter; reference CRC is a reflected LSB-first bytewise model.
module tb_fcs_stream_arbiter;

    localparam int NREQ = 2;
    localparam int IDW  = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ*64-1:0] s_tdata  = '0;
    logic [NREQ*8-1:0]  s_tkeep  = '0;
    logic [NREQ-1:0]    s_tvalid = '0;
    logic [NREQ-1:0]    s_tlast  = '0;
    logic [NREQ-1:0]    s_tready;
    logic [63:0]        m_tdata;
    logic [7:0]         m_tkeep;
    logic               m_tvalid;
    logic               m_tlast;
    logic [IDW-1:0]     m_tid;
    logic               m_tready = 1'b1;
    logic [31:0]        fcs_data;
    logic [IDW-1:0]     fcs_id;
    logic               fcs_valid;
`ifdef FCS_CHECK_EN
    logic               fcs_ok;
`endif

    int checks = 0;
    int fails  = 0;
    int fcs_count = 0;
    int hs_count  = 0;

    logic [63:0] pkt_d [16];
    logic [7:0]  pkt_k [16];
    logic [63:0] bb_d [NREQ];
    logic [7:0]  bb_k [NREQ];

    fcs_stream_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_tdata   (s_tdata),
        .s_tkeep   (s_tkeep),
        .s_tvalid  (s_tvalid),
        .s_tlast   (s_tlast),
        .s_tready  (s_tready),
        .m_tdata   (m_tdata),
        .m_tkeep   (m_tkeep),
        .m_tvalid  (m_tvalid),
        .m_tlast   (m_tlast),
        .m_tid     (m_tid),
        .m_tready  (m_tready),
        .fcs_data  (fcs_data),
        .fcs_id    (fcs_id),
        .fcs_valid (fcs_valid)
`ifdef FCS_CHECK_EN
        ,
        .fcs_ok    (fcs_ok)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fcs_valid === 1'b1) fcs_count++;
        if (m_tvalid === 1'b1 && m_tready === 1'b1) hs_count++;
    end

    // Ethernet FCS of the first n beats in pkt_d/pkt_k, reflected algorithm.
    function automatic logic [31:0] ref_fcs(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int b = 0; b < n; b++)
            for (int i = 0; i < 8; i++)
                if (pkt_k[b][i]) begin
                    c = c ^ {24'h0, pkt_d[b][8*i +: 8]};
                    for (int k = 0; k < 8; k++)
                        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
                end
        return ~c;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        s_tvalid = '0;
        s_tlast  = '0;
        m_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic load_check_vector();
        pkt_d[0] = 64'h3837363534333231; pkt_k[0] = 8'hFF;
        pkt_d[1] = 64'h0000000000000039; pkt_k[1] = 8'h01;
    endtask

    task automatic drive_pkt(input int req, input int n, input bit toggle,
                             output logic [31:0] got, output logic got_ok);
        bit hs;
        int cyc;
        int hs0;
        got = '0;
        got_ok = 1'b0;
        m_tready = 1'b1;
        hs0 = hs_count;
        for (int b = 0; b < n; b++) begin
            s_tvalid[req] = 1'b1;
            s_tdata[64*req +: 64] = pkt_d[b];
            s_tkeep[8*req +: 8] = pkt_k[b];
            s_tlast[req] = (b == n - 1);
            hs = 1'b0;
            cyc = 0;
            while (!hs && cyc < 50) begin
                @(negedge clk);
                hs = (s_tready[req] === 1'b1) && (m_tready === 1'b1);
                if (hs) begin
                    checks++;
                    if (m_tvalid !== 1'b1 || m_tid !== IDW'(req)) begin
                        fails++;
                        $display("FAIL beat_grant: req %0d beat %0d got m_tvalid=%b m_tid=%0d expected 1/%0d", req, b, m_tvalid, m_tid, req);
                    end
                    checks++;
                    if (m_tdata !== pkt_d[b] || m_tkeep !== pkt_k[b] || m_tlast !== (b == n - 1)) begin
                        fails++;
                        $display("FAIL beat_data: req %0d beat %0d got %h/%h/%b expected %h/%h/%b", req, b, m_tdata, m_tkeep, m_tlast, pkt_d[b], pkt_k[b], (b == n - 1));
                    end
                end
                @(posedge clk);
                #1;
                if (toggle) m_tready = ~m_tready;
                cyc++;
            end
            if (!hs) begin
                checks++;
                fails++;
                $display("FAIL beat_timeout: req %0d beat %0d not accepted within 50 cycles", req, b);
                s_tvalid[req] = 1'b0;
                s_tlast[req] = 1'b0;
                return;
            end
        end
        s_tvalid[req] = 1'b0;
        s_tlast[req] = 1'b0;
        @(negedge clk);
        got = fcs_data;
`ifdef FCS_CHECK_EN
        got_ok = fcs_ok;
`endif
        checks++;
        if (fcs_valid !== 1'b1 || fcs_id !== IDW'(req)) begin
            fails++;
            $display("FAIL fcs_strobe: got valid=%b id=%0d expected 1/%0d", fcs_valid, fcs_id, req);
        end
        checks++;
        if (fcs_data !== ref_fcs(n)) begin
            fails++;
            $display("FAIL fcs_value: got %h expected %h", fcs_data, ref_fcs(n));
        end
        checks++;
        if (m_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL bubble: got m_tvalid=%b expected 0", m_tvalid);
        end
        @(negedge clk);
        checks++;
        if (fcs_valid !== 1'b0) begin
            fails++;
            $display("FAIL fcs_one_cycle: got fcs_valid=%b expected 0", fcs_valid);
        end
        checks++;
        if (hs_count - hs0 != n) begin
            fails++;
            $display("FAIL beat_count: got %0d handshakes expected %0d", hs_count - hs0, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (s_tready !== '0 || m_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL reset_handshake: got s_tready=%b m_tvalid=%b expected 0/0", s_tready, m_tvalid);
        end
        checks++;
        if (fcs_valid !== 1'b0 || fcs_data !== 32'h0 || fcs_id !== '0) begin
            fails++;
            $display("FAIL reset_fcs: got %b/%h/%0d expected 0/00000000/0", fcs_valid, fcs_data, fcs_id);
        end
`ifdef FCS_CHECK_EN
        checks++;
        if (fcs_ok !== 1'b0) begin
            fails++;
            $display("FAIL reset_fcs_ok: got %b expected 0", fcs_ok);
        end
`endif
        do_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (m_tvalid !== 1'b0 || fcs_valid !== 1'b0) begin
            fails++;
            $display("FAIL idle_quiet: got m_tvalid=%b fcs_valid=%b expected 0/0", m_tvalid, fcs_valid);
        end
    endtask

    task automatic test_single_req0();
        logic [31:0] got;
        logic ok;
        do_reset();
        load_check_vector();
        drive_pkt(0, 2, 1'b0, got, ok);
        checks++;
        if (got !== 32'hCBF43926) begin
            fails++;
            $display("FAIL single_req0_fcs: got %h expected cbf43926", got);
        end
    endtask

    task automatic test_back_to_back();
        int exp_g;
        int prev_g;
        rst = 1'b1;
        m_tready = 1'b1;
        for (int r = 0; r < NREQ; r++) begin
            bb_d[r] = {$urandom, $urandom};
            bb_k[r] = 8'($urandom);
            s_tdata[64*r +: 64] = bb_d[r];
            s_tkeep[8*r +: 8] = bb_k[r];
        end
        s_tvalid = '1;
        s_tlast = '1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_g = 0;
        prev_g = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            checks++;
            if (m_tvalid !== (k % 2 == 1)) begin
                fails++;
                $display("FAIL b2b_valid: cycle %0d got m_tvalid=%b expected %0d", k, m_tvalid, k % 2);
            end
            if (k % 2 == 1) begin
                checks++;
                if (m_tid !== IDW'(exp_g) || m_tdata !== bb_d[exp_g]) begin
                    fails++;
                    $display("FAIL b2b_grant: cycle %0d got id=%0d data=%h expected %0d/%h", k, m_tid, m_tdata, exp_g, bb_d[exp_g]);
                end
                prev_g = exp_g;
                exp_g = (exp_g + 1) % NREQ;
            end else if (k > 0) begin
                pkt_d[0] = bb_d[prev_g];
                pkt_k[0] = bb_k[prev_g];
                checks++;
                if (fcs_valid !== 1'b1 || fcs_id !== IDW'(prev_g) || fcs_data !== ref_fcs(1)) begin
                    fails++;
                    $display("FAIL b2b_fcs: cycle %0d got %b/%0d/%h expected 1/%0d/%h", k, fcs_valid, fcs_id, fcs_data, prev_g, ref_fcs(1));
                end
            end
        end
        s_tvalid = '0;
        s_tlast = '0;
    endtask

    task automatic test_tready_toggle();
        logic [31:0] got;
        logic ok;
        do_reset();
        load_check_vector();
        drive_pkt(1, 2, 1'b1, got, ok);
        checks++;
        if (got !== 32'hCBF43926) begin
            fails++;
            $display("FAIL toggle_fcs: got %h expected cbf43926", got);
        end
        m_tready = 1'b1;
    endtask

    task automatic test_keep_zero();
        logic [31:0] got;
        logic ok;
        do_reset();
        pkt_d[0] = 64'h3837363534333231; pkt_k[0] = 8'hFF;
        pkt_d[1] = {$urandom, $urandom};  pkt_k[1] = 8'h00;
        pkt_d[2] = 64'h0000000000000039; pkt_k[2] = 8'h01;
        drive_pkt(0, 3, 1'b0, got, ok);
        checks++;
        if (got !== 32'hCBF43926) begin
            fails++;
            $display("FAIL keep_zero_fcs: got %h expected cbf43926", got);
        end
    endtask

    task automatic test_random_packets();
        logic [31:0] got;
        logic ok;
        int req;
        int n;
        do_reset();
        for (int p = 0; p < 8; p++) begin
            req = $urandom_range(0, NREQ - 1);
            n = $urandom_range(1, 5);
            for (int b = 0; b < n; b++) begin
                pkt_d[b] = {$urandom, $urandom};
                pkt_k[b] = 8'($urandom);
            end
            drive_pkt(req, n, 1'($urandom), got, ok);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [31:0] got;
        logic ok;
        bit hs;
        int cyc;
        int cnt0;
        do_reset();
        s_tvalid[1] = 1'b1;
        s_tdata[64 +: 64] = {$urandom, $urandom};
        s_tkeep[8 +: 8] = 8'hFF;
        s_tlast[1] = 1'b0;
        hs = 1'b0;
        cyc = 0;
        while (!hs && cyc < 20) begin
            @(negedge clk);
            hs = (s_tready[1] === 1'b1);
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (!hs) begin
            fails++;
            $display("FAIL rst_mid_beat0: req1 beat0 not accepted within 20 cycles");
        end
        cnt0 = fcs_count;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (m_tvalid !== 1'b0 || s_tready !== '0) begin
            fails++;
            $display("FAIL rst_mid_outputs: got m_tvalid=%b s_tready=%b expected 0/0", m_tvalid, s_tready);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        load_check_vector();
        drive_pkt(0, 2, 1'b0, got, ok);
        checks++;
        if (got !== 32'hCBF43926) begin
            fails++;
            $display("FAIL rst_mid_fcs: got %h expected cbf43926", got);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (fcs_count - cnt0 != 1) begin
            fails++;
            $display("FAIL rst_mid_count: got %0d fcs strobes expected 1", fcs_count - cnt0);
        end
        s_tvalid = '0;
        s_tlast = '0;
    endtask

`ifdef FCS_CHECK_EN
    task automatic test_fcs_check();
        logic [31:0] got;
        logic ok;
        do_reset();
        pkt_d[0] = 64'h3837363534333231; pkt_k[0] = 8'hFF;
        pkt_d[1] = 64'h000000CBF4392639; pkt_k[1] = 8'h1F;
        drive_pkt(0, 2, 1'b0, got, ok);
        checks++;
        if (ok !== 1'b1) begin
            fails++;
            $display("FAIL fcs_ok_good: got %b expected 1", ok);
        end
        pkt_d[0] = 64'h3837363534333230;
        drive_pkt(0, 2, 1'b0, got, ok);
        checks++;
        if (ok !== 1'b0) begin
            fails++;
            $display("FAIL fcs_ok_bad: got %b expected 0", ok);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_req0();
        test_back_to_back();
        test_tready_toggle();
        test_keep_zero();
        test_random_packets();
        test_reset_mid_packet();
`ifdef FCS_CHECK_EN
        test_fcs_check();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
